// File: rtl/stat_bench_sequencer.sv
// Self-test sequencer for a 32-in/32-out Stat benchmark netlist: Galois LFSR patterns, MISR response signature.
// Optional signature comparator enabled by defining STAT_SIG_CHECK_EN.
module stat_bench_sequencer #(
  parameter int               WIDTH      = 32,
  parameter int               CNT_W      = 16,
  parameter int               SETTLE_CYC = 1,
  parameter logic [WIDTH-1:0] LFSR_POLY  = 32'h80200003,
  parameter logic [WIDTH-1:0] LFSR_SEED  = 32'h00000001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] resp_in,
`ifdef STAT_SIG_CHECK_EN
  input  logic [WIDTH-1:0] golden,
  output logic             pass,
  output logic             fail,
`endif
  output logic [WIDTH-1:0] pat_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] pat_count
);

  localparam int SW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] lfsr, misr;
  logic [CNT_W-1:0] n_lat;
  logic [SW-1:0]    settle;
  logic [WIDTH-1:0] lfsr_nxt, misr_nxt;
  logic [CNT_W-1:0] count_inc;

  always_comb begin
    lfsr_nxt  = {lfsr[WIDTH-2:0], 1'b0} ^ (lfsr[WIDTH-1] ? LFSR_POLY : '0);
    misr_nxt  = {misr[WIDTH-2:0], 1'b0} ^ (misr[WIDTH-1] ? LFSR_POLY : '0) ^ resp_in;
    count_inc = pat_count + CNT_W'(1);
  end

  assign pat_out   = lfsr;
  assign signature = misr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= LFSR_SEED;
      misr      <= '0;
      pat_count <= '0;
      n_lat     <= '0;
      settle    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef STAT_SIG_CHECK_EN
      pass      <= 1'b0;
      fail      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // a zero seed would lock the LFSR, so fall back to the reset seed
          if (seed_load) lfsr <= (seed == '0) ? LFSR_SEED : seed;
          if (start && !abort) begin
            misr      <= '0;
            pat_count <= '0;
            n_lat     <= num_patterns;
            settle    <= '0;
`ifdef STAT_SIG_CHECK_EN
            pass      <= 1'b0;
            fail      <= 1'b0;
`endif
            if (num_patterns == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= APPLY;
              busy  <= 1'b1;
            end
          end
        end
        APPLY: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
`ifdef STAT_SIG_CHECK_EN
            pass  <= 1'b0;
            fail  <= 1'b0;
`endif
          end else if (settle == SETTLE_LAST) begin
            state <= CAPTURE;
          end else begin
            settle <= settle + SW'(1);
          end
        end
        CAPTURE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
`ifdef STAT_SIG_CHECK_EN
            pass  <= 1'b0;
            fail  <= 1'b0;
`endif
          end else begin
            misr      <= misr_nxt;
            lfsr      <= lfsr_nxt;
            pat_count <= count_inc;
            settle    <= '0;
            if (count_inc == n_lat) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= APPLY;
            end
          end
        end
        DONE: begin
          state <= IDLE;
`ifdef STAT_SIG_CHECK_EN
          pass  <= (misr == golden);
          fail  <= (misr != golden);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
